// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, ROM addressing and the IF/ID register.
// Optional self-jump halt detection is compiled in with `define HALT_DETECT_EN.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              if_valid,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              halt_hit;

  assign rom_addr = pc;
  assign pc_inc   = pc + ADDR_W'(1);

  // Control priority: redirect_valid beats stall; a redirect always flushes the
  // IF/ID slot (if_valid=0) and loads redirect_pc, while stall alone freezes pc
  // and every IF/ID output. if_pc/if_pc_plus1 keep their last fetched values on
  // a flush so decode sees stable operands alongside if_valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= PC_INIT;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
      if_valid    <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_instr <= '0;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (halted) begin
        if_valid <= 1'b0;
      end else begin
        if_instr    <= rom_data;
        if_pc       <= pc;
        if_pc_plus1 <= pc_inc;
        if_valid    <= 1'b1;
        pc          <= halt_hit ? pc : pc_inc;
      end
    end
  end

`ifdef HALT_DETECT_EN
  // A J-format word (opcode 000010) whose target is its own address spins forever.
  assign halt_hit = (rom_data[31:26] == 6'b000010) && (rom_data[ADDR_W-1:0] == pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= 1'b0;
    end else if (!stall && !halted && halt_hit) begin
      halted <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, expected-value queue, final report.
// Expected halt behaviour follows whether HALT_DETECT_EN is defined for the build.
module tb_fetch_unit;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int W      = DATA_W + 2 * ADDR_W + 2;

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic              if_valid;
  logic              halted;

  logic [DATA_W-1:0] rom [0:31];
  logic [W-1:0]      exp_q[$];
  int                checks = 0;
  int                failures = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .if_valid       (if_valid),
    .halted         (halted)
  );

  assign rom_data = rom[rom_addr];

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of controls, queue the IF/ID state expected after the edge,
  // then sample #1 after that edge and compare against the queue head.
  task automatic step(input logic st, input logic rv, input logic [ADDR_W-1:0] rpc,
                      input string tag, input logic [DATA_W-1:0] e_instr,
                      input logic [ADDR_W-1:0] e_pc, input logic [ADDR_W-1:0] e_pc1,
                      input logic e_valid, input logic e_halt);
    logic [W-1:0] got;
    logic [W-1:0] expv;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    exp_q.push_back({e_instr, e_pc, e_pc1, e_valid, e_halt});
    @(posedge clk);
    #1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    got  = {if_instr, if_pc, if_pc_plus1, if_valid, halted};
    expv = exp_q.pop_front();
    check(tag, 64'(got), 64'(expv));
  endtask

  task automatic run(input string tag, input logic [DATA_W-1:0] e_instr,
                     input logic [ADDR_W-1:0] e_pc, input logic [ADDR_W-1:0] e_pc1);
    step(1'b0, 1'b0, '0, tag, e_instr, e_pc, e_pc1, 1'b1, 1'b0);
  endtask

  task automatic redir(input logic [ADDR_W-1:0] rpc, input string tag,
                       input logic [ADDR_W-1:0] e_pc, input logic [ADDR_W-1:0] e_pc1);
    step(1'b0, 1'b1, rpc, tag, '0, e_pc, e_pc1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0]  = 32'h0000_0800;
    rom[1]  = 32'h2402_000B;
    rom[2]  = 32'h8C23_0000;
    rom[3]  = 32'h2421_0001;
    rom[11] = 32'h0800_000B;

    // reset state, held across edges
    #1;
    check("rst_valid", 64'(if_valid), 64'(0));
    check("rst_instr", 64'(if_instr), 64'(0));
    check("rst_addr", 64'(rom_addr), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_held", 64'(if_valid), 64'(0));
    rst = 1'b0;

    // sequential fetch of the program
    run("seq0", 32'h0000_0800, 5'd0, 5'd1);
    run("seq1", 32'h2402_000B, 5'd1, 5'd2);
    run("seq2", 32'h8C23_0000, 5'd2, 5'd3);
    run("seq3", 32'h2421_0001, 5'd3, 5'd4);
    run("seq4", rom[4], 5'd4, 5'd5);

    // three stalled edges at pc=5
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, "stall_hold", rom[4], 5'd4, 5'd5, 1'b1, 1'b0);
      check("stall_addr", 64'(rom_addr), 64'(5));
    end
    run("stall_resume", rom[5], 5'd5, 5'd6);

    // stall and redirect together at pc=6
    step(1'b1, 1'b1, 5'd10, "stall_redir", '0, 5'd5, 5'd6, 1'b0, 1'b0);
    check("stall_redir_addr", 64'(rom_addr), 64'(10));
    run("redir_target", rom[10], 5'd10, 5'd11);

    // wrap-around at the top of the ROM
    redir(5'd31, "wrap_redir", 5'd10, 5'd11);
    run("wrap_top", rom[31], 5'd31, 5'd0);
    check("wrap_addr0", 64'(rom_addr), 64'(0));
    run("wrap_zero", 32'h0000_0800, 5'd0, 5'd1);
    check("wrap_addr1", 64'(rom_addr), 64'(1));

    // redirect to the current pc refetches it
    redir(5'd1, "self_redir", 5'd0, 5'd1);
    check("self_redir_addr", 64'(rom_addr), 64'(1));
    run("self_refetch", 32'h2402_000B, 5'd1, 5'd2);

    // back-to-back redirects: the last target wins
    redir(5'd20, "redir_a", 5'd1, 5'd2);
    redir(5'd6, "redir_b", 5'd1, 5'd2);
    run("redir_last", rom[6], 5'd6, 5'd7);

    // self-jump at word 11
    redir(5'd11, "halt_redir", 5'd6, 5'd7);
    step(1'b0, 1'b0, '0, "halt_fetch", 32'h0800_000B, 5'd11, 5'd12, 1'b1, HALT_EN);
    check("halt_addr", 64'(rom_addr), HALT_EN ? 64'(11) : 64'(12));
    if (HALT_EN) begin
      step(1'b0, 1'b0, '0, "halted_a", 32'h0800_000B, 5'd11, 5'd12, 1'b0, 1'b1);
      check("halted_addr_a", 64'(rom_addr), 64'(11));
      step(1'b0, 1'b0, '0, "halted_b", 32'h0800_000B, 5'd11, 5'd12, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, "halted_stall", 32'h0800_000B, 5'd11, 5'd12, 1'b0, 1'b1);
      check("halted_addr_b", 64'(rom_addr), 64'(11));
      redir(5'd0, "unhalt_redir", 5'd11, 5'd12);
    end else begin
      run("nohalt_a", rom[12], 5'd12, 5'd13);
      check("nohalt_addr", 64'(rom_addr), 64'(13));
      run("nohalt_b", rom[13], 5'd13, 5'd14);
      step(1'b1, 1'b0, '0, "nohalt_stall", rom[13], 5'd13, 5'd14, 1'b1, 1'b0);
      redir(5'd11, "refetch_redir", 5'd13, 5'd14);
      run("refetch_jump", 32'h0800_000B, 5'd11, 5'd12);
      redir(5'd0, "unhalt_redir", 5'd11, 5'd12);
    end
    run("resume_zero", 32'h0000_0800, 5'd0, 5'd1);

    // asynchronous reset mid-cycle while stalled at pc=7
    redir(5'd6, "pre_rst_redir", 5'd0, 5'd1);
    run("pre_rst_fetch", rom[6], 5'd6, 5'd7);
    check("pre_rst_addr", 64'(rom_addr), 64'(7));
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", 64'(rom_addr), 64'(0));
    check("arst_ifid", 64'({if_instr, if_pc, if_pc_plus1, if_valid, halted}), 64'(0));
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst   = 1'b0;
    check("post_rst_addr", 64'(rom_addr), 64'(0));
    run("post_rst_fetch", 32'h0000_0800, 5'd0, 5'd1);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
